// File: rtl/muldiv_if.sv
// Handshake and result bus between the core EX stage and the multiply/divide unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with architectural Hi/Lo.
// op: 00 MUL, 01 MULU, 10 DIV, 11 DIVU. Operands are reduced to magnitudes at
// accept, iterated WIDTH times, and sign-corrected in a final FIX cycle.
// Optional macro MULDIV_EARLY_TERM_EN: multiplies leave CALC as soon as the
// remaining multiplier bits are all zero.
//
// state | meaning
// IDLE  | waiting for start; hi/lo hold the last result
// CALC  | one multiply/divide iteration per enabled edge
// FIX   | sign correction, hi/lo write, done pulse
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset_n,
  input logic       en,
  muldiv_if.slave   bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam int         CW   = $clog2(WIDTH);

  logic [1:0]         state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // Multiply: shifted multiplicand. Divide: divisor in the low half.
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  // Multiply: multiplier shifting right. Divide: dividend in, quotient out.
  logic [WIDTH-1:0]   shr_q, shr_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  logic               acc_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   rem_diff;
  logic               q_bit;
  logic               last_iter;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign acc_signed = ~bus.op[0];
  assign a_neg      = acc_signed & bus.a[WIDTH-1];
  assign b_neg      = acc_signed & bus.b[WIDTH-1];
  assign a_abs      = a_neg ? (~bus.a + 1'b1) : bus.a;
  assign b_abs      = b_neg ? (~bus.b + 1'b1) : bus.b;

  // Restoring step: the WIDTH+1-bit partial remainder never exceeds 2*divisor.
  assign rem_sh   = {rem_q, shr_q[WIDTH-1]};
  assign rem_diff = {1'b0, rem_sh} - {2'b00, mcand_q[WIDTH-1:0]};
  assign q_bit    = ~rem_diff[WIDTH+1];

  // A zero divisor leaves remainder = |a|, which the dividend sign restores to a.
  assign prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
  assign quo_fix  = dz_q ? {WIDTH{1'b1}} : (neg_res_q ? (~shr_q + 1'b1) : shr_q);
  assign rem_fix  = neg_rem_q ? (~rem_q + 1'b1) : rem_q;

`ifdef MULDIV_EARLY_TERM_EN
  assign last_iter = (cnt_q == CW'(WIDTH - 1)) ||
                     (!op_q[1] && (shr_q[WIDTH-1:1] == '0));
`else
  assign last_iter = (cnt_q == CW'(WIDTH - 1));
`endif

  // Next-state and datapath for the accept / iterate / fix sequence.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    shr_d      = shr_q;
    rem_d      = rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.cancel) begin
          op_d       = bus.op;
          cnt_d      = '0;
          neg_res_d  = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          dz_d       = bus.op[1] && (bus.b == '0);
          acc_d      = '0;
          rem_d      = '0;
          div_zero_d = 1'b0;
          if (bus.op[1]) begin
            mcand_d = {{WIDTH{1'b0}}, b_abs};
            shr_d   = a_abs;
          end else begin
            mcand_d = {{WIDTH{1'b0}}, a_abs};
            shr_d   = b_abs;
          end
          state_d = CALC;
        end
      end
      CALC: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else begin
          if (op_q[1]) begin
            rem_d = q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            shr_d = {shr_q[WIDTH-2:0], q_bit};
          end else begin
            if (shr_q[0]) acc_d = acc_q + mcand_q;
            mcand_d = mcand_q << 1;
            shr_d   = shr_q >> 1;
          end
          cnt_d = cnt_q + 1'b1;
          if (last_iter) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!bus.cancel) begin
          done_d = 1'b1;
          if (op_q[1]) begin
            hi_d       = rem_fix;
            lo_d       = quo_fix;
            div_zero_d = dz_q;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All registers advance only on enabled edges; reset clears everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      cnt_q      <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      acc_q      <= '0;
      mcand_q    <= '0;
      shr_q      <= '0;
      rem_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (en) begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      shr_q      <= shr_d;
      rem_q      <= rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.busy     = (state_q == CALC) || (state_q == FIX);
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit (WIDTH=32) against an
// arithmetic reference model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk;
  logic reset_n;
  logic en;
  int   n_assert;
  int   n_fail;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {div_zero, hi, lo} from plain signed/unsigned arithmetic.
  function automatic logic [64:0] model_op(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned up;
    int              qa, qb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: begin
        p = sa * sb;
        return {1'b0, 64'(p)};
      end
      2'd1: begin
        up = {32'd0, a} * {32'd0, b};
        return {1'b0, 64'(up)};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (op == 2'd2) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
          qa = $signed(a);
          qb = $signed(b);
          return {1'b0, 32'(qa % qb), 32'(qa / qb)};
        end
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [31:0] b);
`ifdef MULDIV_EARLY_TERM_EN
    logic [31:0] mag;
    if (!op[1]) begin
      mag = (!op[0] && b[31]) ? -b : b;
      for (int i = 31; i >= 0; i--) if (mag[i]) return i + 2;
      return 2;
    end
`endif
    return W + 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one op (accepted on the next edge), waits for done and checks
  // latency, busy duration and results. Optionally freezes en mid-op or on done,
  // and toggles start/operand noise while busy.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int freeze_at, input bit freeze_done,
                        input bit noise);
    logic [64:0] exp;
    int          lat, n, busy_cnt;
    bit          seen;
    exp = model_op(op, a, b);
    lat = model_lat(op, b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    step();
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    busy_cnt  = bus.busy ? 1 : 0;
    n         = 0;
    seen      = 1'b0;
    while (!seen && n < 200) begin
      if (n == freeze_at) begin
        en = 1'b0;
        repeat (5) step();
        en = 1'b1;
      end
      if (noise) begin
        bus.start = 1'($urandom);
        bus.op    = 2'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
      end
      step();
      n++;
      if (bus.done) begin
        seen      = 1'b1;
        bus.start = 1'b0;
      end else if (bus.busy) begin
        busy_cnt++;
      end
    end
    chk({tag, ".done_seen"}, 64'(seen), 64'd1);
    chk({tag, ".latency"}, 64'(n), 64'(lat));
    chk({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(lat));
    chk({tag, ".hi_lo"}, {bus.hi, bus.lo}, exp[63:0]);
    chk({tag, ".div_zero"}, 64'(bus.div_zero), 64'(exp[64]));
    if (freeze_done) begin
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
        step();
        chk({tag, ".done_frozen"}, 64'(bus.done), 64'd1);
      end
      en = 1'b1;
      step();
      chk({tag, ".done_pulse_end"}, 64'(bus.done), 64'd0);
      chk({tag, ".hi_lo_after_freeze"}, {bus.hi, bus.lo}, exp[63:0]);
    end
  endtask

  initial begin
    logic [63:0] prev;
    logic [31:0] ra, rb;
    int          dn;
    n_assert   = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    en         = 1'b1;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bus.op     = 2'd0;
    bus.a      = '0;
    bus.b      = '0;
    repeat (3) step();
    chk("reset.flags", {61'd0, bus.busy, bus.done, bus.div_zero}, 64'd0);
    chk("reset.hi_lo", {bus.hi, bus.lo}, 64'd0);
    reset_n = 1'b1;
    step();

    run_op("mul_neg3x7", 2'd0, 32'hFFFF_FFFD, 32'd7, -1, 0, 0);
    run_op("mulu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 0, 0);
    run_op("div_neg7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, -1, 0, 0);
    run_op("divu_by0", 2'd3, 32'd100, 32'd0, -1, 0, 0);
    run_op("mulu_5x3", 2'd1, 32'd5, 32'd3, -1, 0, 0);
    run_op("div_min_m1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0, 0);
    run_op("div_neg_by0", 2'd2, 32'hFFFF_FF00, 32'd0, -1, 0, 0);
    run_op("divu_15_3", 2'd3, 32'd15, 32'd3, -1, 0, 0);
    run_op("mul_min_min", 2'd0, 32'h8000_0000, 32'h8000_0000, -1, 0, 0);
    run_op("mul_prev", 2'd0, 32'h0001_2345, 32'hFFFF_FFF7, -1, 0, 0);

    // cancel during CALC: no done, results untouched
    prev      = {bus.hi, bus.lo};
    bus.start = 1'b1;
    bus.op    = 2'd1;
    bus.a     = 32'd5;
    bus.b     = 32'd3;
    step();
    bus.start = 1'b0;
    repeat (9) step();
    chk("cancel.busy_before", 64'(bus.busy), 64'd1);
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    chk("cancel.busy_after", 64'(bus.busy), 64'd0);
    dn = 0;
    repeat (40) begin
      step();
      if (bus.done) dn++;
    end
    chk("cancel.no_done", 64'(dn), 64'd0);
    chk("cancel.hi_lo_kept", {bus.hi, bus.lo}, prev);

    // cancel beats start in IDLE
    bus.start  = 1'b1;
    bus.cancel = 1'b1;
    step();
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    chk("idle_cancel.no_accept", 64'(bus.busy), 64'd0);
    step();
    chk("idle_cancel.still_idle", 64'(bus.busy), 64'd0);

    // enable freeze mid-CALC and while done is high
    run_op("en_freeze", 2'd1, 32'hDEAD_BEEF, 32'h0123_4567, 6, 1, 0);

    // asynchronous reset mid-op
    bus.start = 1'b1;
    bus.op    = 2'd3;
    bus.a     = 32'd77;
    bus.b     = 32'd0;
    step();
    bus.start = 1'b0;
    repeat (10) step();
    chk("prereset.hi_lo_nonzero", 64'({bus.hi, bus.lo} != 64'd0), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("midreset.flags", {61'd0, bus.busy, bus.done, bus.div_zero}, 64'd0);
    chk("midreset.hi_lo", {bus.hi, bus.lo}, 64'd0);
    step();
    reset_n = 1'b1;
    step();

    // randomized ops, with corner operands mixed in and start noise while busy
    for (int k = 0; k < 60; k++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'($urandom_range(0, 300));
        4: ra = 32'($urandom_range(0, 300));
        default: ;
      endcase
      run_op("random", 2'($urandom), ra, rb, -1, 0, 1'(k % 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
